// File: rtl/ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx
//
// Purpose:
//   Receives a PS/2 keyboard on its raw pins and turns the device-to-host
//   traffic into key events for the keyboard-matrix logic. Both lines are
//   synchronised (2 flops) and deglitched (saturating run-length filter).
//   11-bit frames are deframed on the filtered clock's falling edges and
//   checked for start, odd parity and stop. E0/F0 prefix bytes are folded
//   into the extended/released flags of the next non-prefix byte.
//
// Ports:
//   clk               system clock (sysclk)
//   power_on_reset_n  synchronous active-low reset
//   clkps2, dataps2   raw PS/2 clock and data pins (asynchronous)
//   scancode          last completed non-prefix byte
//   extended          E0 prefix preceded scancode
//   released          F0 prefix preceded scancode (break code)
//   kb_strobe         one-cycle pulse, scancode/extended/released valid
//   rx_error          one-cycle pulse, frame rejected
//   busy              frame in progress
//
// Handshake: kb_strobe is a valid-only pulse with no ready; the consumer
// must take scancode/extended/released in the strobe cycle. The outputs
// then hold until the next strobe.
// ---------------------------------------------------------------------------
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 28000
) (
   input  logic       clk,
   input  logic       power_on_reset_n,
   input  logic       clkps2,
   input  logic       dataps2,
   output logic [7:0] scancode,
   output logic       extended,
   output logic       released,
   output logic       kb_strobe,
   output logic       rx_error,
   output logic       busy
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // synchroniser and filter state
   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic [FW-1:0] clk_cnt;
   logic [FW-1:0] dat_cnt;
   logic          clk_filt;
   logic          dat_filt;
   logic          clk_filt_d;
   logic          fall;

   // frame state
   state_t        state, state_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          parity_bit, parity_bit_nxt;
   logic [TW-1:0] tcount, tcount_nxt;
   logic          ext_flag, ext_flag_nxt;
   logic          rel_flag, rel_flag_nxt;

   // output registers
   logic [7:0]    scancode_nxt;
   logic          extended_nxt;
   logic          released_nxt;
   logic          kb_strobe_nxt;
   logic          rx_error_nxt;

   // -------------------------------------------------------------------------
   // Synchronise and deglitch. The filtered level only follows the pin after
   // FILTER_LEN consecutive samples disagree with it; any agreeing sample
   // restarts the run.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!power_on_reset_n) begin
         clk_sync   <= 2'b11;
         dat_sync   <= 2'b11;
         clk_cnt    <= '0;
         dat_cnt    <= '0;
         clk_filt   <= 1'b1;
         dat_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[0], clkps2};
         dat_sync   <= {dat_sync[0], dataps2};
         clk_filt_d <= clk_filt;

         if (clk_sync[1] == clk_filt) begin
            clk_cnt <= '0;
         end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= '0;
         end else begin
            clk_cnt <= clk_cnt + FW'(1);
         end

         if (dat_sync[1] == dat_filt) begin
            dat_cnt <= '0;
         end else if (dat_cnt == FW'(FILTER_LEN - 1)) begin
            dat_filt <= dat_sync[1];
            dat_cnt  <= '0;
         end else begin
            dat_cnt <= dat_cnt + FW'(1);
         end
      end
   end

   assign fall = clk_filt_d & ~clk_filt;
   assign busy = (state != ST_IDLE);

   // -------------------------------------------------------------------------
   // Frame FSM: next state, datapath and registered outputs.
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      bit_idx_nxt    = bit_idx;
      shift_nxt      = shift;
      parity_bit_nxt = parity_bit;
      tcount_nxt     = tcount;
      ext_flag_nxt   = ext_flag;
      rel_flag_nxt   = rel_flag;
      scancode_nxt   = scancode;
      extended_nxt   = extended;
      released_nxt   = released;
      kb_strobe_nxt  = 1'b0;
      rx_error_nxt   = 1'b0;

      // The timeout counter only runs inside a frame and restarts on every
      // clock edge, so it measures the gap since the last bit.
      if (state == ST_IDLE || fall) begin
         tcount_nxt = '0;
      end else begin
         tcount_nxt = tcount + TW'(1);
      end

      if (state != ST_IDLE && !fall && tcount == TW'(TIMEOUT_CYCLES - 1)) begin
         // device stalled mid-frame: abandon it
         state_nxt    = ST_IDLE;
         tcount_nxt   = '0;
         rx_error_nxt = 1'b1;
         ext_flag_nxt = 1'b0;
         rel_flag_nxt = 1'b0;
      end else if (fall) begin
         case (state)
            ST_IDLE: begin
               if (!dat_filt) begin
                  state_nxt   = ST_DATA;
                  bit_idx_nxt = 3'd0;
               end else begin
                  rx_error_nxt = 1'b1;
                  ext_flag_nxt = 1'b0;
                  rel_flag_nxt = 1'b0;
               end
            end
            ST_DATA: begin
               // LSB arrives first, so shift in from the top
               shift_nxt = {dat_filt, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_nxt = ST_PARITY;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
            ST_PARITY: begin
               parity_bit_nxt = dat_filt;
               state_nxt      = ST_STOP;
            end
            ST_STOP: begin
               state_nxt = ST_IDLE;
               if (dat_filt && (^{shift, parity_bit})) begin
                  if (shift == 8'hE0) begin
                     ext_flag_nxt = 1'b1;
                  end else if (shift == 8'hF0) begin
                     rel_flag_nxt = 1'b1;
                  end else begin
                     scancode_nxt  = shift;
                     extended_nxt  = ext_flag;
                     released_nxt  = rel_flag;
                     kb_strobe_nxt = 1'b1;
                     ext_flag_nxt  = 1'b0;
                     rel_flag_nxt  = 1'b0;
                  end
               end else begin
                  rx_error_nxt = 1'b1;
                  ext_flag_nxt = 1'b0;
                  rel_flag_nxt = 1'b0;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!power_on_reset_n) begin
         state      <= ST_IDLE;
         bit_idx    <= 3'd0;
         shift      <= 8'h00;
         parity_bit <= 1'b0;
         tcount     <= '0;
         ext_flag   <= 1'b0;
         rel_flag   <= 1'b0;
         scancode   <= 8'h00;
         extended   <= 1'b0;
         released   <= 1'b0;
         kb_strobe  <= 1'b0;
         rx_error   <= 1'b0;
      end else begin
         state      <= state_nxt;
         bit_idx    <= bit_idx_nxt;
         shift      <= shift_nxt;
         parity_bit <= parity_bit_nxt;
         tcount     <= tcount_nxt;
         ext_flag   <= ext_flag_nxt;
         rel_flag   <= rel_flag_nxt;
         scancode   <= scancode_nxt;
         extended   <= extended_nxt;
         released   <= released_nxt;
         kb_strobe  <= kb_strobe_nxt;
         rx_error   <= rx_error_nxt;
      end
   end

endmodule
